// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package ssd_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 32;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOAD,
    ST_SHOW,
    ST_BLANK
  } ssd_state_e;

  // All anodes off (active low); callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_off();
    return '1;
  endfunction

endpackage

// File: rtl/ssd_refresh_prescaler.sv
// Free-running 0..MAX-1 counter with synchronous clear and terminal-count pulse.
module ssd_refresh_prescaler #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tc_c
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] count;

  assign tc_c = run && (count == CW'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (run) begin
      count <= tc_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexes a NUM_DIGITS hex value onto one shared seven-segment decoder.
// Optional inter-digit ghost blanking is enabled by defining SSD_GHOST_BLANK_EN.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  output logic [NIBBLE_W-1:0]            cnt,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           frame_done
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = NUM_DIGITS'(anode_off());

  ssd_state_e                     state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NIBBLE_W-1:0]            cnt_d;
  logic [NUM_DIGITS-1:0]          an_d;
  logic                           frame_done_d;
  logic                           refresh_tc;
  logic                           blank_tc;

  ssd_refresh_prescaler #(.MAX(REFRESH_DIV)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_SHOW),
    .run  (state_q == ST_SHOW),
    .tc_c (refresh_tc)
  );

`ifdef SSD_GHOST_BLANK_EN
  ssd_refresh_prescaler #(.MAX(BLANK_CYCLES)) u_blank (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_BLANK),
    .run  (state_q == ST_BLANK),
    .tc_c (blank_tc)
  );
`else
  logic unused_blank;
  assign unused_blank = ^BLANK_CYCLES;
  assign blank_tc     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      idx_q      <= '0;
      shadow_q   <= '0;
      an         <= ANODE_OFF;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      an         <= an_d;
      cnt        <= cnt_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    an_d         = ANODE_OFF;
    cnt_d        = cnt;

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shadow_d     = value_in;
        idx_d        = '0;
        frame_done_d = 1'b1;
        state_d      = ST_SHOW;
      end
      ST_SHOW: begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        cnt_d = shadow_q[NIBBLE_W*idx_q +: NIBBLE_W];
        if (refresh_tc) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_LOAD;
          end else begin
`ifdef SSD_GHOST_BLANK_EN
            state_d = ST_BLANK;
`else
            idx_d   = idx_q + IW'(1);
`endif
          end
        end
      end
`ifdef SSD_GHOST_BLANK_EN
      ST_BLANK: begin
        if (blank_tc) begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SHOW;
        end
      end
`endif
      default: state_d = ST_OFF;
    endcase

    // Dropping enable abandons the frame without capturing or signalling.
    if (!en) begin
      state_d      = ST_OFF;
      idx_d        = '0;
      shadow_d     = shadow_q;
      frame_done_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux against a frame-position reference model.
module tb_ssd_scan_mux;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;
`ifdef SSD_GHOST_BLANK_EN
  localparam int unsigned B = 2;
`else
  localparam int unsigned B = 0;
`endif
  localparam int unsigned SLOT      = R + B;
  localparam int unsigned FRAME_LEN = 1 + N * R + (N - 1) * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  cnt;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  ssd_scan_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .value_in  (value_in),
    .cnt       (cnt),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: position within a frame (0 = capture cycle), outputs one edge later.
  bit          m_on = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  e_an = 4'hF;
  logic [3:0]  e_cnt = 4'h0;
  logic        e_fd = 1'b0;

  always @(posedge clk) begin : model
    int off;
    int d;
    if (rst) begin
      e_an = 4'hF; e_cnt = 4'h0; e_fd = 1'b0;
      m_on = 1'b0; m_pos = 0; m_shadow = '0;
    end else begin
      e_fd = 1'b0;
      if (!m_on) begin
        e_an = 4'hF; e_cnt = 4'h0;
      end else if (m_pos == 0) begin
        e_an = 4'hF; e_fd = en;
      end else begin
        off = m_pos - 1;
        d   = off / SLOT;
        if ((off % SLOT) < R) begin
          e_an  = ~(4'(1) << d);
          e_cnt = m_shadow[4*d +: 4];
        end else begin
          e_an = 4'hF;
        end
      end
      if (!en) begin
        m_on = 1'b0;
      end else if (!m_on) begin
        m_on = 1'b1; m_pos = 0;
      end else begin
        if (m_pos == 0) m_shadow = value_in;
        m_pos = (m_pos + 1 == FRAME_LEN) ? 0 : m_pos + 1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; value_in = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || cnt !== 4'h0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b cnt=%h fd=%b required an=1111 cnt=0 fd=0", an, cnt, frame_done);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || cnt !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release an=%b cnt=%h fd=%b required an=1111 cnt=0 fd=0", an, cnt, frame_done);
    end
  endtask

  task automatic test_scan();
    value_in = 16'h1234;
    repeat (2 * FRAME_LEN) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL scan t=%0t an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", $time, an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_scan an=%b required at most one low", an);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !hit; i++) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL midchg_wait an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
      if (e_an == 4'b1101) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midchg_timeout digit1 not reached got=0 required=1");
    end
    value_in = 16'hABCD;
    repeat (2 * FRAME_LEN) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL midchg t=%0t an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", $time, an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_midchg an=%b required at most one low", an);
      end
    end
  endtask

  task automatic test_frame_period();
    bit hit = 1'b0;
    int period = 0;
    for (int i = 0; i < 2 * FRAME_LEN && !hit; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL period_timeout no frame_done got=0 required=1");
    end
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !hit; i++) begin
      @(negedge clk);
      period++;
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_period an=%b required at most one low", an);
      end
      if (frame_done === 1'b1) hit = 1'b1;
    end
    checks++;
    if (period != FRAME_LEN) begin
      errors++;
      $display("FAIL frame_period got=%0d required=%0d", period, FRAME_LEN);
    end
  endtask

  task automatic test_enable_drop();
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !hit; i++) begin
      @(negedge clk);
      if (e_an == 4'b1011) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL endrop_timeout digit2 not reached got=0 required=1");
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL endrop_fd cycle=%0d got=%b required=0", i, frame_done);
      end
      if (i >= 1) begin
        checks++;
        if (an !== 4'hF) begin
          errors++;
          $display("FAIL endrop_dark cycle=%0d an=%b required=1111", i, an);
        end
      end
    end
    en = 1'b1;
    value_in = 16'($urandom);
    repeat (FRAME_LEN + 5) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL restart t=%0t an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", $time, an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_restart an=%b required at most one low", an);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !hit; i++) begin
      @(negedge clk);
      if (e_an == 4'b0111) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_timeout digit3 not reached got=0 required=1");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || cnt !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid an=%b cnt=%h fd=%b required an=1111 cnt=0 fd=0", an, cnt, frame_done);
    end
    rst = 1'b0;
    repeat (FRAME_LEN + 3) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL rstmid_run t=%0t an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", $time, an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      @(negedge clk);
      checks++;
      if (an !== e_an || cnt !== e_cnt || frame_done !== e_fd) begin
        errors++;
        $display("FAIL random t=%0t an=%b/%b cnt=%h/%h fd=%b/%b (got/required)", $time, an, e_an, cnt, e_cnt, frame_done, e_fd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_random an=%b required at most one low", an);
      end
      value_in = 16'($urandom);
      en       = ($urandom_range(0, 29) != 0);
      rst      = ($urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_change();
    test_frame_period();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
